// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// The tick input is a square wave at OS times the baud rate. Each rising edge
// of tick becomes a one-clk sample enable.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames with an even
// parity bit. Without it, frames are 8N1 and parity_err is tied low.
module uart_rx #(
  parameter int OS  = 16,
  parameter int MID = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  localparam logic [3:0] CNT_LAST = 4'(OS - 1);
  localparam logic [3:0] CNT_MID  = 4'(MID);

  logic       rx_meta, rx_s;
  logic       tick_q, en;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, frame_err_nxt, parity_err_nxt;
`ifdef UART_RX_PARITY_EN
  logic       par_bad, par_bad_nxt;
`endif

  // Two-flop synchroniser for rx and edge detector for tick.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would collapse the two sync stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      tick_q  <= tick;
    end
  end

  assign en   = tick & ~tick_q;
  assign busy = (state != IDLE);

  // State, counters, shift register and registered output pulses.
  // NOTE: the reset is synchronous, so it only takes effect on a clk edge;
  // every flop in this block, including data, has an explicit reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      data       <= data_nxt;
      valid      <= valid_nxt;
      frame_err  <= frame_err_nxt;
      parity_err <= parity_err_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_nxt;
`endif
    end
  end

  // Next-state and pulse logic. This logic advances only on sample enables.
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    data_nxt       = data;
    valid_nxt      = 1'b0;
    frame_err_nxt  = 1'b0;
    parity_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt    = par_bad;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt_nxt = '0;
            if (!rx_s) begin
              state_nxt   = DATA;
              bit_idx_nxt = '0;
            end else begin
              state_nxt = IDLE;  // glitch: too short to be a start bit
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            shreg_nxt = {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt   = PARITY;
`else
              state_nxt   = STOP;
`endif
            end else begin
              bit_idx_nxt = bit_idx + 3'd1;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt     = '0;
            par_bad_nxt = ^{shreg, rx_s};  // even parity: the XOR must be 0
            state_nxt   = STOP;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (rx_s) begin
              state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err_nxt = 1'b1;
              end else begin
                data_nxt  = shreg;
                valid_nxt = 1'b1;
              end
`else
              data_nxt  = shreg;
              valid_nxt = 1'b1;
`endif
            end else begin
              state_nxt     = WAIT_IDLE;  // a bad stop bit is always reported as a framing error
              frame_err_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx. A frame-level model
// predicts the event sequence: valid with the new byte, or frame_err/parity_err
// with the byte previously held. A monitor records the pulses the DUT produces.
module tb_uart_rx;
  localparam int OS  = 16;
  localparam int MID = 7;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick = 1'b0;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(.OS(OS), .MID(MID)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx), .data(data),
    .valid(valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;  // 100 MHz

  // Tick generator: a square wave that toggles every tick_half clocks.
  int tick_half = 27;
  int tick_cnt  = 0;
  always @(negedge clk) begin
    if (tick_cnt >= tick_half - 1) begin
      tick_cnt = 0;
      tick     = ~tick;
    end else begin
      tick_cnt++;
    end
  end

  typedef enum {EV_VALID, EV_FRAME, EV_PARITY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         multi = 0;
  logic [7:0] last_good = 8'h00;
  int         passed = 0;
  int         total  = 0;

  // Monitor: record every pulse and count clocks where more than one pulse is high.
  always @(negedge clk) begin
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) multi++;
    if (valid === 1'b1)      obs_q.push_back('{EV_VALID, data});
    if (frame_err === 1'b1)  obs_q.push_back('{EV_FRAME, data});
    if (parity_err === 1'b1) obs_q.push_back('{EV_PARITY, data});
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS * 2 * tick_half) @(negedge clk);
  endtask

  // Drive one frame and append the event the frame must produce.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit((^b) ^ par_flip);
    drive_bit(stop_bit);
    if (!stop_bit) begin
      exp_q.push_back('{EV_FRAME, last_good});
    end else if (PAR_EN && par_flip) begin
      exp_q.push_back('{EV_PARITY, last_good});
    end else begin
      exp_q.push_back('{EV_VALID, b});
      last_good = b;
    end
  endtask

  task automatic clear_scoreboard();
    obs_q.delete();
    exp_q.delete();
    multi = 0;
  endtask

  task automatic test_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", parity_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst = 1'b0;
    last_good = 8'h00;
    clear_scoreboard();
  endtask

  task automatic test_basic();
    tick_half = 27;  // about 115200 baud with 16x oversampling at 100 MHz
    clear_scoreboard();
    drive_bit(1'b1);
    send_frame(8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1);
    total++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy); else passed++;
    total++; if (data !== 8'hA5) $display("FAIL basic_data: got %h expected a5", data); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data)
        $display("FAIL basic_event%0d: got kind=%0d data=%h expected kind=%0d data=%h", i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
      else passed++;
    end
    total++; if (multi !== 0) $display("FAIL basic_exclusive: got %0d overlaps expected 0", multi); else passed++;
  endtask

  task automatic test_glitch();
    tick_half = 3;
    clear_scoreboard();
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (3 * 2 * tick_half) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL glitch_busy_high: got %b expected 1", busy); else passed++;
    rx = 1'b1;
    repeat ((MID + 3) * 2 * tick_half) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy_low: got %b expected 0", busy); else passed++;
    total++; if (obs_q.size() !== 0) $display("FAIL glitch_pulses: got %0d expected 0", obs_q.size()); else passed++;
  endtask

  task automatic test_frame_err();
    clear_scoreboard();
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    total++; if (data !== 8'hA5) $display("FAIL frame_data_kept: got %h expected a5", data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL frame_busy: got %b expected 0", busy); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL frame_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data)
        $display("FAIL frame_event%0d: got kind=%0d data=%h expected kind=%0d data=%h", i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    clear_scoreboard();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data)
        $display("FAIL b2b_event%0d: got kind=%0d data=%h expected kind=%0d data=%h", i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
      else passed++;
    end
    total++; if (multi !== 0) $display("FAIL b2b_exclusive: got %0d overlaps expected 0", multi); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h55;
    clear_scoreboard();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (OS * tick_half) @(negedge clk);  // half-way through bit 4
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
    total++; if (data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", data); else passed++;
    rst = 1'b0;
    last_good = 8'h00;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    drive_bit(1'b1);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data)
        $display("FAIL rstmid_event%0d: got kind=%0d data=%h expected kind=%0d data=%h", i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop_bit, par_flip;
    clear_scoreboard();
    for (int n = 0; n < 14; n++) begin
      b        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 5) != 0);
      par_flip = ($urandom_range(0, 3) == 0);
      send_frame(b, stop_bit, par_flip);
      if (!stop_bit) begin
        drive_bit(1'b1);
        drive_bit(1'b1);
      end else if ($urandom_range(0, 1) == 1) begin
        drive_bit(1'b1);
      end
    end
    drive_bit(1'b1);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data)
        $display("FAIL random_event%0d: got kind=%0d data=%h expected kind=%0d data=%h", i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
      else passed++;
    end
    total++; if (multi !== 0) $display("FAIL random_exclusive: got %0d overlaps expected 0", multi); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL random_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_parity();
    clear_scoreboard();
    send_frame(8'h07, 1'b1, 1'b0);  // parity bit 1: correct for even parity
    drive_bit(1'b1);
    send_frame(8'h07, 1'b1, 1'b1);  // parity bit 0: mismatch
    drive_bit(1'b1);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL parity_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data)
        $display("FAIL parity_event%0d: got kind=%0d data=%h expected kind=%0d data=%h", i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    if (PAR_EN) test_parity();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OS, default 16, meaning tick enables per bit period (oversampling ratio).
REQ-002 SHALL have parameter MID, default 7, meaning tick enable index within the start bit at which the start bit is confirmed.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tick  input  1  free-running square wave from the baud tick generator, OS times the baud rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  8  last correctly received byte.
REQ-008 SHALL have port valid  output  1  one-clk pulse when data is updated.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse on a bad stop bit.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse on a parity mismatch.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL synchronise rx through two flip-flops (reset value 1); all decisions use the second stage.
REQ-013 SHALL register tick and form a one-clk sample enable (en) on each 0->1 transition of tick only.
REQ-014 SHALL change state and the 4-bit sample counter (cnt) only on clocks with en=1.
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-016 IDLE: synchronised rx=0 -> START with cnt=0.
REQ-017 START: at cnt=MID, rx=0 -> DATA with cnt=0 and bit index 0; rx=1 -> IDLE with no output pulse (glitch reject).
REQ-018 DATA: at cnt=OS-1, shift rx into the shift register LSB first; after bit index 7, go to PARITY (macro defined) or STOP, with cnt=0.
REQ-019 cnt SHALL wrap from OS-1 to 0; bit index 0..7 SHALL never wrap inside a frame.
REQ-020 STOP: at cnt=OS-1, rx=1 -> IDLE, data <= shift register, valid=1 on the next clk.
REQ-021 STOP: at cnt=OS-1, rx=0 -> WAIT_IDLE, frame_err=1 on the next clk, data unchanged.
REQ-022 WAIT_IDLE: remain until rx=1 is sampled on an en, then go to IDLE, so a break condition yields exactly one frame_err.
REQ-023 valid, frame_err and parity_err SHALL each be high for exactly one clk per event and SHALL be mutually exclusive.
REQ-024 A new start bit SHALL be accepted on the first en after the STOP->IDLE transition, so back-to-back frames with no idle gap are received.

Reset
REQ-025 rst=1 SHALL force within one clk: state IDLE, cnt 0, bit index 0, shift register 0x00, data 0x00, valid 0, frame_err 0, parity_err 0, busy 0, both sync flops 1, registered tick 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no pulses; reception resumes at the next falling edge after rst is released.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: frames are 8E1; the PARITY state samples at cnt=OS-1.
REQ-028 With the macro, if XOR(data bits, parity bit)=1: parity_err=1, data unchanged, and the STOP state is still traversed, with no valid pulse.
REQ-029 With the macro, a frame with a parity error and a bad stop bit SHALL report frame_err only.
REQ-030 Macro undefined: frames are 8N1, the PARITY state is absent, and parity_err is tied to 0.

Verification
REQ-031 8N1 byte 0xA5 at 115200 with tick from the generator at 100 MHz -> exactly one valid pulse, data=0xA5, busy low afterwards.
REQ-032 rx low for 3 en only, then high -> no pulses, busy returns to 0 within MID+1 en.
REQ-033 0x3C sent with stop bit 0, then line high -> one frame_err, data keeps previous value 0xA5, no valid pulse.
REQ-034 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-035 rst pulsed during bit 4 of 0x55, then 0x81 sent -> only 0x81 reported, with one valid pulse.
REQ-036 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid, data=0x07; parity bit 0 -> parity_err only.
